// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calc issue stage.
//   OPCODE_CALC      default custom-0 opcode accepted as a calc instruction
//   FUNCT3_BMI/BMR   funct3 encodings of the two legal calc operations
//   calc_state_t     issue FSM states
//   *_LSB / *_MSB    R-type instruction field positions
//   calc_dec_t       decoder output bundle
package calc_pkg;

    localparam logic [6:0] OPCODE_CALC = 7'b0001011;
    localparam logic [2:0] FUNCT3_BMI  = 3'b000;
    localparam logic [2:0] FUNCT3_BMR  = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        OUT  = 2'd2
    } calc_state_t;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    typedef struct packed {
        logic       is_bmi;
        logic       is_bmr;
        logic       illegal;
        logic [4:0] rd;
        logic [6:0] funct7;
    } calc_dec_t;

endpackage

// File: rtl/calc_decode.sv
// calc_decode: purely combinational decode of an R-type calc instruction.
//   instr  in  32  raw instruction word
//   dec    out     {is_bmi, is_bmr, illegal, rd, funct7}; at most one select set,
//                  illegal set whenever neither select is set
module calc_decode #(
    parameter logic [6:0] OPCODE_CALC = calc_pkg::OPCODE_CALC
) (
    input  logic [31:0]         instr,
    output calc_pkg::calc_dec_t dec
);
    import calc_pkg::*;

    // Register-source fields travel separately as operand data.
    logic unused_rs_fields_s;
    assign unused_rs_fields_s = ^instr[RS2_MSB:FUNCT3_MSB+1] ^ instr[RS1_MSB];

    // Field extraction and legality check.
    always_comb begin
        dec        = '0;
        dec.rd     = instr[RD_MSB:RD_LSB];
        dec.funct7 = instr[FUNCT7_MSB:FUNCT7_LSB];
        if (instr[OPCODE_MSB:OPCODE_LSB] == OPCODE_CALC) begin
            case (instr[FUNCT3_MSB:FUNCT3_LSB])
                FUNCT3_BMI: dec.is_bmi  = 1'b1;
                FUNCT3_BMR: dec.is_bmr  = 1'b1;
                default:    dec.illegal = 1'b1;
            endcase
        end else begin
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/calc_issue_unit.sv
// calc_issue_unit: single-entry issue stage in front of the combinational BMI/BMR ALU.
// Accepts one instruction + operands, holds the ALU inputs for ALU_LAT cycles,
// captures the ALU result and offers it to writeback with valid/ready.
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready, in_instr,        instruction input handshake and operands
//   in_rs1_data (height), in_rs2_data (weight)
//   alu_is_calc_bmi/bmr, alu_height,    registered ALU control and data
//   alu_weight, alu_funct7, alu_result  (alu_result is the ALU's combinational answer)
//   out_valid/out_ready, out_rd,        result output handshake
//   out_result, out_illegal
module calc_issue_unit #(
    parameter logic [6:0] OPCODE_CALC = calc_pkg::OPCODE_CALC,
    parameter int         ALU_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        alu_is_calc_bmi,
    output logic        alu_is_calc_bmr,
    output logic [31:0] alu_height,
    output logic [31:0] alu_weight,
    output logic [6:0]  alu_funct7,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic        out_illegal
);
    import calc_pkg::*;

    // The count runs ALU_LAT-1 down to 0 so the inputs are held exactly ALU_LAT cycles.
    localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

    calc_state_t state_r;
    calc_state_t state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic        accept_s;
    logic        capture_s;
    logic        release_s;
    logic        illegal_r;
    logic [4:0]  rd_r;
    calc_dec_t   dec_s;

    calc_decode #(.OPCODE_CALC(OPCODE_CALC)) u_decode (
        .instr (in_instr),
        .dec   (dec_s)
    );

    // Next-state, counter and strobe logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s    = 1'b1;
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == 4'd0) begin
                    capture_s   = 1'b1;
                    state_nxt_s = OUT;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    release_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered outputs; handshake flags are derived from the next state so they
    // never depend combinationally on in_valid or out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready        <= 1'b1;
            out_valid       <= 1'b0;
            alu_is_calc_bmi <= 1'b0;
            alu_is_calc_bmr <= 1'b0;
            alu_height      <= 32'd0;
            alu_weight      <= 32'd0;
            alu_funct7      <= 7'd0;
            rd_r            <= 5'd0;
            illegal_r       <= 1'b0;
            out_rd          <= 5'd0;
            out_result      <= 32'd0;
            out_illegal     <= 1'b0;
        end else begin
            in_ready  <= (state_nxt_s == IDLE);
            out_valid <= (state_nxt_s == OUT);
            if (accept_s) begin
                alu_is_calc_bmi <= dec_s.is_bmi;
                alu_is_calc_bmr <= dec_s.is_bmr;
                alu_height      <= in_rs1_data;
                alu_weight      <= in_rs2_data;
                alu_funct7      <= dec_s.funct7;
                rd_r            <= dec_s.rd;
                illegal_r       <= dec_s.illegal;
            end else if (release_s) begin
                // Operands stay put; only the op selects are withdrawn.
                alu_is_calc_bmi <= 1'b0;
                alu_is_calc_bmr <= 1'b0;
            end
            if (capture_s) begin
                out_rd      <= rd_r;
                out_illegal <= illegal_r;
                out_result  <= illegal_r ? 32'd0 : alu_result;
            end
        end
    end

endmodule

// File: tb/tb_calc_issue_unit.sv
module tb_calc_issue_unit;

    localparam int LAT = 2;
    localparam logic [6:0] OPC = 7'b0001011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready;
    logic [31:0] in_instr, rs1, rs2;
    logic        in_ready, bmi, bmr, out_valid, out_illegal;
    logic [31:0] h, w, alu_res, out_result;
    logic [6:0]  f7;
    logic [4:0]  out_rd;

    // ALU stand-in: answers only for the exact operand sets under test.
    assign alu_res = bmi ? ((h == 32'd175 && w == 32'd70) ? 32'd2287 : 32'hBAD00001) :
                     bmr ? ((h == 32'd175 && w == 32'd70 && f7 == 7'b1011110) ? 32'd1648 : 32'hBAD00002) :
                     32'hDEADBEEF;

    calc_issue_unit #(.ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1_data(rs1), .in_rs2_data(rs2),
        .alu_is_calc_bmi(bmi), .alu_is_calc_bmr(bmr), .alu_height(h), .alu_weight(w),
        .alu_funct7(f7), .alu_result(alu_res), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_result(out_result), .out_illegal(out_illegal)
    );

    // Latency-sweep instances: always valid, always ready.
    logic        sw_rst_n, sw_valid;
    logic [31:0] sw_instr;
    logic        sw1_in_ready, sw15_in_ready;
    logic        unused_1_bmi, unused_1_bmr, unused_1_ov, unused_1_ill;
    logic        unused_15_bmi, unused_15_bmr, unused_15_ov, unused_15_ill;
    logic [31:0] unused_1_h, unused_1_w, unused_1_res, unused_15_h, unused_15_w, unused_15_res;
    logic [6:0]  unused_1_f7, unused_15_f7;
    logic [4:0]  unused_1_rd, unused_15_rd;

    calc_issue_unit #(.ALU_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(sw_rst_n), .in_valid(sw_valid), .in_ready(sw1_in_ready),
        .in_instr(sw_instr), .in_rs1_data(32'd175), .in_rs2_data(32'd70),
        .alu_is_calc_bmi(unused_1_bmi), .alu_is_calc_bmr(unused_1_bmr), .alu_height(unused_1_h),
        .alu_weight(unused_1_w), .alu_funct7(unused_1_f7), .alu_result(32'd42),
        .out_valid(unused_1_ov), .out_ready(1'b1), .out_rd(unused_1_rd),
        .out_result(unused_1_res), .out_illegal(unused_1_ill)
    );

    calc_issue_unit #(.ALU_LAT(15)) u_lat15 (
        .clk(clk), .rst_n(sw_rst_n), .in_valid(sw_valid), .in_ready(sw15_in_ready),
        .in_instr(sw_instr), .in_rs1_data(32'd175), .in_rs2_data(32'd70),
        .alu_is_calc_bmi(unused_15_bmi), .alu_is_calc_bmr(unused_15_bmr), .alu_height(unused_15_h),
        .alu_weight(unused_15_w), .alu_funct7(unused_15_f7), .alu_result(32'd42),
        .out_valid(unused_15_ov), .out_ready(1'b1), .out_rd(unused_15_rd),
        .out_result(unused_15_res), .out_illegal(unused_15_ill)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        illegal;
        int          acc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] fn7, input logic [4:0] rd,
                                       input logic [2:0] fn3, input logic [6:0] opc);
        return {fn7, 5'd2, 5'd1, fn3, rd, opc};
    endfunction

    // Monitor: latency, hold-stability and scoreboard pops on the main DUT.
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_ill = 1'b0;
    logic [4:0]  prev_rd = 5'd0;
    logic [31:0] prev_res = 32'd0;
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: out_valid=1 with nothing in flight, required 0");
            end else begin
                chk("latency", cyc - sb[0].acc, LAT);
            end
        end
        if (out_valid && prev_valid && !prev_ready) begin
            chk("hold_rd", out_rd, prev_rd);
            chk("hold_result", out_result, prev_res);
            chk("hold_illegal", out_illegal, prev_ill);
        end
        if (out_valid && out_ready && sb.size() > 0) begin
            chk("out_rd", out_rd, sb[0].rd);
            chk("out_result", out_result, sb[0].result);
            chk("out_illegal", out_illegal, sb[0].illegal);
            sb.delete(0);
        end
        prev_valid <= out_valid;
        prev_ready <= out_ready;
        prev_rd    <= out_rd;
        prev_res   <= out_result;
        prev_ill   <= out_illegal;
    end

    // Sweep monitor: spacing between successive acceptances.
    int sw1_last = -1, sw15_last = -1, sw1_n = 0, sw15_n = 0;
    always @(negedge clk) begin
        if (sw_valid && sw1_in_ready) begin
            if (sw1_last >= 0) chk("sweep_lat1_interval", cyc - sw1_last, 3);
            sw1_last <= cyc;
            sw1_n    <= sw1_n + 1;
        end
        if (sw_valid && sw15_in_ready) begin
            if (sw15_last >= 0) chk("sweep_lat15_interval", cyc - sw15_last, 17);
            sw15_last <= cyc;
            sw15_n    <= sw15_n + 1;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0 || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: pending=%0d in_ready=%0b, required 0 and 1", sb.size(), in_ready);
        end
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_bmi, input logic exp_bmr, input logic [4:0] rd,
                         input logic [31:0] res, input logic ill);
        int n = 0;
        logic [31:0] iw;
        iw = instr;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready=0 required 1");
        end else begin
            in_instr = instr; rs1 = a; rs2 = b; in_valid = 1'b1;
            @(posedge clk); #1;
            sb.push_back('{rd, res, ill, cyc});
            in_valid = 1'b0;
            chk("in_ready_busy", in_ready, 0);
            chk("sel_bmi", bmi, exp_bmi);
            chk("sel_bmr", bmr, exp_bmr);
            chk("alu_height", h, a);
            chk("alu_weight", w, b);
            chk("alu_funct7", f7, iw[31:25]);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; sw_rst_n = 1'b0; sw_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
        sw_instr = mk(7'b1011110, 5'd1, 3'b000, OPC);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sel", {bmi, bmr}, 0);
        chk("reset_out_rd", out_rd, 0);
        chk("reset_out_result", out_result, 0);
        chk("reset_out_illegal", out_illegal, 0);
        chk("reset_height", h, 0);
        rst_n = 1'b1; sw_rst_n = 1'b1; sw_valid = 1'b1;
        @(posedge clk); #1;

        // BMR, BMI, illegal opcode, illegal funct3, rd=0
        issue(mk(7'b1011110, 5'd5, 3'b001, OPC), 32'd175, 32'd70, 1'b0, 1'b1, 5'd5, 32'd1648, 1'b0);
        issue(mk(7'b1011110, 5'd3, 3'b000, OPC), 32'd175, 32'd70, 1'b1, 1'b0, 5'd3, 32'd2287, 1'b0);
        wait_idle();
        chk("sel_drop_idle", {bmi, bmr}, 0);
        chk("height_held_idle", h, 175);
        issue(mk(7'b1011110, 5'd7, 3'b000, 7'b0110011), 32'd175, 32'd70, 1'b0, 1'b0, 5'd7, 32'd0, 1'b1);
        issue(mk(7'b1011110, 5'd9, 3'b111, OPC), 32'd175, 32'd70, 1'b0, 1'b0, 5'd9, 32'd0, 1'b1);
        issue(mk(7'b1011110, 5'd0, 3'b000, OPC), 32'd175, 32'd70, 1'b1, 1'b0, 5'd0, 32'd2287, 1'b0);
        wait_idle();

        // Backpressure: 10 stalled cycles with a second instruction waiting.
        out_ready = 1'b0;
        issue(mk(7'b1011110, 5'd5, 3'b001, OPC), 32'd175, 32'd70, 1'b0, 1'b1, 5'd5, 32'd1648, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_out_valid_rise", out_valid, 1);
        in_instr = mk(7'b1011110, 5'd3, 3'b000, OPC); in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sel_bmr", bmr, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_back", in_ready, 1);
        @(posedge clk); #1;
        sb.push_back('{5'd3, 32'd2287, 1'b0, cyc});
        in_valid = 1'b0;
        chk("bp_second_accepted", in_ready, 0);
        chk("bp_second_sel_bmi", bmi, 1);
        wait_idle();

        // Reset one cycle into EXEC: everything drops at once, nothing emerges later.
        issue(mk(7'b1011110, 5'd5, 3'b001, OPC), 32'd175, 32'd70, 1'b0, 1'b1, 5'd5, 32'd1648, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_sel", {bmi, bmr}, 0);
        chk("rst_mid_height", h, 0);
        chk("rst_mid_out_rd", out_rd, 0);
        chk("rst_mid_out_result", out_result, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("rst_no_out_valid", out_valid, 0);
        end

        wait_idle();
        chk("sweep_lat1_count", (sw1_n >= 10) ? 1 : 0, 1);
        chk("sweep_lat15_count", (sw15_n >= 3) ? 1 : 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_issue_unit.md
# calc_issue_unit

Sequential issue stage directly upstream of the combinational BMI/BMR `alu`. It accepts one R-type custom instruction plus its two operand values over a valid/ready handshake and decodes it into the ALU control and data inputs. It holds those inputs stable for a programmable settle window, captures the ALU result, and presents it with the destination register index on a valid/ready output toward writeback.

## Interface
- `OPCODE_CALC`, default 7'b0001011 (custom-0): opcode accepted as a calc instruction.
- `ALU_LAT`, default 2: cycles the ALU inputs are held before the result is sampled (1..15).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  instruction and operands are presented.
- `in_ready`  out  1  unit can accept an instruction.
- `in_instr`  in  32  instruction: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode[6:0].
- `in_rs1_data`  in  32  height operand (cm).
- `in_rs2_data`  in  32  weight operand (kg).
- `alu_is_calc_bmi`, `alu_is_calc_bmr`  out  1 each  ALU op select; never both 1.
- `alu_height`, `alu_weight`  out  32 each  registered operands.
- `alu_funct7`  out  7  registered funct7: [6] gender, [5:0] age.
- `alu_result`  in  32  combinational ALU output.
- `out_valid`  out  1  result is available.
- `out_ready`  in  1  downstream accepts the result.
- `out_rd`  out  5  destination register.
- `out_result`  out  32  captured result.
- `out_illegal`  out  1  instruction was not a legal calc op; `out_result` is 0.

## Operation
- The FSM has three states.
  - IDLE: `in_ready`=1. On `in_valid`, latch the decoded fields and move to EXEC.
  - EXEC: `in_ready`=0. Count down from `ALU_LAT`-1. When the count reaches 0, register `alu_result` into `out_result` and move to OUT.
  - OUT: `out_valid`=1. On `out_ready`, return to IDLE.
- Decode is legal when opcode == `OPCODE_CALC` and funct3 is 3'b000 (BMI) or 3'b001 (BMR).
  - BMI drives `alu_is_calc_bmi`=1.
  - BMR drives `alu_is_calc_bmr`=1.
- Illegal opcode or funct3:
  - Both selects stay 0 and the EXEC wait still runs its full length (fixed latency).
  - `out_illegal`=1 and `out_result`=0.
- `rd`=0 is legal; the result is still returned, and discarding it is writeback's job.
- The ALU select and data registers hold their values from acceptance until the next acceptance. The selects drop to 0 on return to IDLE.
- `out_rd`, `out_result` and `out_illegal` stay stable while `out_valid`=1 and `out_ready`=0.
- There is no back-to-back overlap: exactly one instruction is in flight.

## Timing
- Reset values of all outputs are 0, with one exception: `in_ready` is 1. The FSM resets to IDLE and the counter to 0.
- Acceptance happens at the edge where `in_valid` and `in_ready` are both 1 (cycle 0). The ALU inputs are valid from cycle 1.
- `out_valid` rises at cycle `ALU_LAT`+1. With `out_ready` held at 1, `in_ready` returns at cycle `ALU_LAT`+2.
- Throughput is one instruction per `ALU_LAT`+2 cycles.
- `in_ready` is a registered, state-derived signal. It must not depend combinationally on `in_valid` or `out_ready`.
- If `rst_n` is asserted mid-EXEC or mid-OUT, the instruction is dropped. `out_valid` falls immediately (asynchronously), and no partial result is emitted after release.
- If `in_valid` is asserted while the FSM is in EXEC or OUT, the instruction is ignored. The upstream stage must hold it.

## Structure
- Shared package `calc_pkg`:
  - `OPCODE_CALC`
  - `FUNCT3_BMI`=3'b000 and `FUNCT3_BMR`=3'b001
  - state enum `calc_state_t` {IDLE, EXEC, OUT}
  - instruction field slice constants
- Sub-module `calc_decode` is purely combinational. It maps instr to {is_bmi, is_bmr, illegal, rd, funct7}.
- The top level instantiates `calc_decode`, the FSM and the counter. The `alu` is instantiated by the parent, not inside this unit.

## Test plan
- BMR with the real `alu` connected: instr funct7=7'b1011110 (male, age 30), funct3=001, rd=5, rs1_data=175, rs2_data=70 -> `out_valid` at cycle `ALU_LAT`+1, `out_rd`=5, `out_result`=1648, `out_illegal`=0.
- BMI: funct3=000, rd=3, rs1_data=175, rs2_data=70 -> `alu_is_calc_bmi`=1 during EXEC, `out_result`=2287, `out_rd`=3.
- Illegal: opcode=7'b0110011 or funct3=3'b111 -> both ALU selects 0, `out_illegal`=1, `out_result`=0, same latency as a legal op.
- Backpressure: hold `out_ready`=0 for 10 cycles -> `out_valid`, `out_rd` and `out_result` stay stable, `in_ready` stays 0, and a second `in_valid` is not accepted. It is accepted in the cycle after `out_ready`=1.
- Reset mid-EXEC: pulse `rst_n` low at cycle 1 -> all outputs return to their reset values immediately, and no `out_valid` follows.
- Latency sweep: `ALU_LAT`=1 and `ALU_LAT`=15 with back-to-back `in_valid` and `out_ready`=1 -> instructions accepted exactly every `ALU_LAT`+2 cycles.
